// File: rtl/arashi_arb_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter.
// Thread count is derived from its log2 width; weight slices are located by thread index.
package arashi_arb_pkg;

    localparam int unsigned ARB_MAX_TNW = 6;
    localparam int unsigned ARB_MIN_TNW = 1;

    // Bit offset of one thread's slice inside the packed weight vector.
    typedef int unsigned arb_wslice_base_t;

    function automatic int unsigned thread_num(input int unsigned width);
        return 32'd1 << width;
    endfunction

    function automatic arb_wslice_base_t wslice_base(input int unsigned idx,
                                                     input int unsigned ww);
        return idx * ww;
    endfunction

endpackage

// File: rtl/arashi_rr_pick.sv
// Rotating priority encoder: first set bit of req at or after index start, wrapping around.
// Any thread count works, because the rotate is a doubled-vector slice.
module arashi_rr_pick
    import arashi_arb_pkg::*;
#(
    parameter int unsigned THREAD_NUM_WIDTH = 2
) (
    input  logic [thread_num(THREAD_NUM_WIDTH)-1:0] req,
    input  logic [THREAD_NUM_WIDTH-1:0]             start,
    output logic                                    any,
    output logic [THREAD_NUM_WIDTH-1:0]             idx
);

    localparam int unsigned ThreadNum = thread_num(THREAD_NUM_WIDTH);

    logic [2*ThreadNum-1:0]        req_dbl;
    logic [ThreadNum-1:0]          req_rot;
    logic [THREAD_NUM_WIDTH-1:0]   off;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[start +: ThreadNum];

    // Scan from the top so the lowest set bit is the one left in off.
    always_comb begin
        off = '0;
        for (int i = int'(ThreadNum) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = THREAD_NUM_WIDTH'(i);
            end
        end
    end

    assign any = |req;
    assign idx = start + off;

endmodule

// File: rtl/arashi_wrr_arbiter.sv
// Weighted round-robin arbiter that selects the next thread whose cache read is issued.
// Each winner keeps a burst of up to its weight in grants. The grant is held until gnt_ready.
module arashi_wrr_arbiter
    import arashi_arb_pkg::*;
#(
    parameter int unsigned THREAD_NUM_WIDTH = 2,
    parameter int unsigned WEIGHT_WIDTH     = 3
) (
    input  logic                                                clk,
    input  logic                                                rstn,
    input  logic [thread_num(THREAD_NUM_WIDTH)-1:0]             avail,
    input  logic [thread_num(THREAD_NUM_WIDTH)*WEIGHT_WIDTH-1:0] weight,
    output logic                                                gnt_valid,
    input  logic                                                gnt_ready,
    output logic [THREAD_NUM_WIDTH-1:0]                         gnt_id,
    output logic                                                gnt_last
);

    if (THREAD_NUM_WIDTH < ARB_MIN_TNW || THREAD_NUM_WIDTH > ARB_MAX_TNW) begin : g_bad_width
        $error("arashi_wrr_arbiter: THREAD_NUM_WIDTH must be within 1..6");
    end

    logic                        gnt_valid_q, gnt_valid_d;
    logic [THREAD_NUM_WIDTH-1:0] gnt_id_q, gnt_id_d;
    logic                        gnt_last_q, gnt_last_d;
    logic [THREAD_NUM_WIDTH-1:0] last_q, last_d;
    logic [WEIGHT_WIDTH-1:0]     credit_q, credit_d;

    logic                        slot_free;
    logic                        burst_cont;
    logic                        pick_any;
    logic [THREAD_NUM_WIDTH-1:0] pick_start;
    logic [THREAD_NUM_WIDTH-1:0] pick_idx;
    logic [WEIGHT_WIDTH-1:0]     pick_w;
    logic [WEIGHT_WIDTH-1:0]     pick_ew;

    assign slot_free  = !gnt_valid_q || gnt_ready;
    assign burst_cont = (credit_q != '0) && avail[last_q];
    assign pick_start = last_q + 1'b1;

    arashi_rr_pick #(
        .THREAD_NUM_WIDTH (THREAD_NUM_WIDTH)
    ) u_rr_pick (
        .req   (avail),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign pick_w  = weight[wslice_base(32'(pick_idx), WEIGHT_WIDTH) +: WEIGHT_WIDTH];
    // A zero weight still earns a single grant.
    assign pick_ew = (pick_w == '0) ? WEIGHT_WIDTH'(1) : pick_w;

    always_comb begin
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        gnt_last_d  = gnt_last_q;
        last_d      = last_q;
        credit_d    = credit_q;
        if (slot_free) begin
            if (burst_cont) begin
                gnt_valid_d = 1'b1;
                gnt_id_d    = last_q;
                credit_d    = credit_q - 1'b1;
                gnt_last_d  = (credit_q == WEIGHT_WIDTH'(1));
            end else if (pick_any) begin
                gnt_valid_d = 1'b1;
                gnt_id_d    = pick_idx;
                last_d      = pick_idx;
                credit_d    = pick_ew - 1'b1;
                gnt_last_d  = (pick_ew == WEIGHT_WIDTH'(1));
            end else begin
                gnt_valid_d = 1'b0;
                credit_d    = '0;
                gnt_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            gnt_last_q  <= 1'b0;
            last_q      <= '1;
            credit_q    <= '0;
        end else begin
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            gnt_last_q  <= gnt_last_d;
            last_q      <= last_d;
            credit_q    <= credit_d;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_last  = gnt_last_q;

endmodule

// File: tb/tb_arashi_wrr_arbiter.sv
// Directed bench for arashi_wrr_arbiter: a behavioural model is compared every cycle,
// and literal expectations pin the grant sequences of each scenario.
module tb_arashi_wrr_arbiter;

    localparam int TNW = 2;
    localparam int WW  = 3;
    localparam int TN  = 1 << TNW;

    logic            clk;
    logic            rstn;
    logic [TN-1:0]   avail;
    logic [TN*WW-1:0] weight;
    logic            gnt_valid;
    logic            gnt_ready;
    logic [TNW-1:0]  gnt_id;
    logic            gnt_last;

    int checks = 0;
    int errors = 0;

    arashi_wrr_arbiter #(
        .THREAD_NUM_WIDTH (TNW),
        .WEIGHT_WIDTH     (WW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .avail     (avail),
        .weight    (weight),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .gnt_id    (gnt_id),
        .gnt_last  (gnt_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: plain integers and a modulo search over thread indices.
    int m_valid, m_id, m_glast, m_last, m_credit;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid  = 0;
            m_id     = 0;
            m_glast  = 0;
            m_credit = 0;
            m_last   = TN - 1;
        end else if (m_valid == 0 || gnt_ready) begin
            if (m_credit > 0 && avail[m_last]) begin
                m_valid  = 1;
                m_id     = m_last;
                m_glast  = (m_credit == 1) ? 1 : 0;
                m_credit = m_credit - 1;
            end else begin
                int hit;
                hit = -1;
                for (int off = 1; off <= TN; off++) begin
                    int k;
                    k = (m_last + off) % TN;
                    if (hit < 0 && avail[k]) hit = k;
                end
                if (hit >= 0) begin
                    int w, ew;
                    w        = int'((weight >> (hit * WW)) & 12'h7);
                    ew       = (w == 0) ? 1 : w;
                    m_valid  = 1;
                    m_id     = hit;
                    m_last   = hit;
                    m_credit = ew - 1;
                    m_glast  = (ew == 1) ? 1 : 0;
                end else begin
                    m_valid  = 0;
                    m_credit = 0;
                    m_glast  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("model_valid", int'(gnt_valid), m_valid);
            check("model_id", int'(gnt_id), m_id);
            if (m_valid != 0) check("model_last", int'(gnt_last), m_glast);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_w(input int i, input int v);
        weight[i*WW +: WW] = WW'(v);
    endtask

    task automatic all_w(input int v);
        for (int i = 0; i < TN; i++) set_w(i, v);
    endtask

    initial begin
        int exp_id3 [8];
        int exp_l3  [8];
        rstn      = 1'b0;
        avail     = '0;
        gnt_ready = 1'b1;
        all_w(1);
        repeat (3) tick();
        rstn = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", int'(gnt_valid), 0);
            check("idle_id", int'(gnt_id), 0);
            check("idle_last", int'(gnt_last), 0);
        end

        // 2: all request, weight 1
        avail = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_valid", int'(gnt_valid), 1);
            check("rr_id", int'(gnt_id), i % 4);
            check("rr_last", int'(gnt_last), 1);
        end
        avail = '0;
        tick();
        check("rr_drain", int'(gnt_valid), 0);

        // 3: weighted pair
        avail = 4'b0011;
        set_w(0, 3);
        set_w(1, 1);
        exp_id3 = '{0, 0, 0, 1, 0, 0, 0, 1};
        exp_l3  = '{0, 0, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 8; i++) begin
            tick();
            check("wrr_id", int'(gnt_id), exp_id3[i]);
            check("wrr_last", int'(gnt_last), exp_l3[i]);
        end
        avail = '0;
        tick();

        // 4: stall holds grant
        all_w(1);
        avail = 4'b0100;
        tick();
        check("stall_first", int'(gnt_id), 2);
        gnt_ready = 1'b0;
        avail     = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_id", int'(gnt_id), 2);
            check("stall_valid", int'(gnt_valid), 1);
        end
        gnt_ready = 1'b1;
        tick();
        check("stall_next", int'(gnt_id), 3);
        avail = '0;
        tick();

        // 5: single requester, weight 0 then 2
        avail = 4'b0010;
        set_w(1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("w0_id", int'(gnt_id), 1);
            check("w0_last", int'(gnt_last), 1);
        end
        set_w(1, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("w2_id", int'(gnt_id), 1);
            check("w2_last", int'(gnt_last), i % 2);
        end
        avail = '0;
        tick();

        // 6: burst abort, then asynchronous reset
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        all_w(1);
        set_w(0, 4);
        avail = 4'b0001;
        tick();
        check("abort_g0a", int'(gnt_id), 0);
        avail = 4'b0101;
        tick();
        check("abort_g0b", int'(gnt_id), 0);
        avail = 4'b0100;
        tick();
        check("abort_next", int'(gnt_id), 2);
        #2;
        rstn = 1'b0;
        #1;
        check("async_valid", int'(gnt_valid), 0);
        check("async_id", int'(gnt_id), 0);
        avail = 4'b1111;
        #2;
        rstn = 1'b1;
        tick();
        check("post_rst_id", int'(gnt_id), 0);
        check("post_rst_valid", int'(gnt_valid), 1);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
